// File: rtl/uart_pkg.sv
// Shared constants for the Wishbone UART transmitter: register map,
// bit positions and the serialiser state encoding.
package uart_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd3;
   localparam logic [2:0] ADDR_BAUD   = 3'd4;
   localparam logic [2:0] ADDR_STATUS = 3'd5;
   localparam logic [2:0] ADDR_TXBUF  = 3'd7;

   localparam int unsigned BIT_START     = 7;
   localparam int unsigned BIT_BUSY      = 7;
   localparam int unsigned BIT_IE        = 0;
   localparam int unsigned BIT_TX_DONE   = 5;
   localparam int unsigned BIT_OVR       = 6;
   localparam int unsigned BIT_STAT_BUSY = 0;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

endpackage

// File: rtl/uart_tx_wb_if.sv
// Wishbone classic slave bus bundle; signal names are seen from the slave side.
interface uart_tx_wb_if #(
   parameter int unsigned ADDR_W = 32
);
   logic [ADDR_W-1:0] addr_i;
   logic [31:0]       dat_i;
   logic [31:0]       dat_o;
   logic              we_i;
   logic [3:0]        sel_i;
   logic              cyc_i;
   logic              stb_i;
   logic              ack_o;
   logic              err_o;
   logic              rty_o;

   modport master (
      output addr_i, dat_i, we_i, sel_i, cyc_i, stb_i,
      input  dat_o, ack_o, err_o, rty_o
   );

   modport slave (
      input  addr_i, dat_i, we_i, sel_i, cyc_i, stb_i,
      output dat_o, ack_o, err_o, rty_o
   );
endinterface

// File: rtl/uart_baud_nco.sv
// Phase-accumulator baud generator: tick is the carry-out of acc + increment.
module uart_baud_nco (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        clear,
   input  logic [31:0] increment,
   output logic        tick
);
   logic [31:0] acc_q, acc_d;
   logic        carry;

   always_comb begin
      {carry, acc_d} = {1'b0, acc_q} + {1'b0, increment};
      tick = enable & carry;
      if (clear) begin
         acc_d = '0;
      end else if (!enable) begin
         acc_d = acc_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
endmodule

// File: rtl/uart_tx_wb.sv
// Wishbone slave UART transmitter: register file plus an 8N1 serialiser
// paced by the baud NCO.
module uart_tx_wb
   import uart_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   uart_tx_wb_if.slave    wb,
   output logic           tx_o,
   output logic           irq_o
);
   tx_state_e   state_q, state_d;
   logic [31:0] baud_q, baud_d;
   logic [31:0] dat_o_q, dat_o_d;
   logic [31:0] rdata;
   logic [7:0]  txbuf_q, txbuf_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  idx_q, idx_d;
   logic        ie_q, ie_d;
   logic        done_q, done_d;
   logic        ovr_q, ovr_d;
   logic        tx_q, tx_d;
   logic        ack_q;
   logic        wr, rd, busy, tick, start_cmd, frame_end;
   logic [2:0]  a;
   logic        unused;

   assign a         = wb.addr_i[2:0];
   assign wr        = wb.stb_i & wb.we_i;
   assign rd        = wb.stb_i & ~wb.we_i;
   assign busy      = (state_q != IDLE);
   assign start_cmd = wr && (a == ADDR_CTRL) && wb.dat_i[BIT_START] && !busy;
   assign unused    = ^{wb.sel_i, wb.cyc_i, wb.addr_i[ADDR_W-1:3]};

   uart_baud_nco u_nco (
      .clk       (clk_i),
      .rst       (rst_i),
      .enable    (busy),
      .clear     (start_cmd),
      .increment (baud_q),
      .tick      (tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      frame_end = 1'b0;
      tx_d      = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (start_cmd) begin
               state_d = START;
               shift_d = txbuf_q;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (tick) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            tx_d = shift_q[0];
            if (tick) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (tick) begin
               state_d   = IDLE;
               frame_end = 1'b1;
            end
         end
      endcase
   end

   // Status clear is applied before the sets so a same-edge frame end wins.
   always_comb begin
      baud_d  = baud_q;
      txbuf_d = txbuf_q;
      ie_d    = ie_q;
      done_d  = done_q;
      ovr_d   = ovr_q;
      if (wr) begin
         case (a)
            ADDR_CTRL: begin
               ie_d = wb.dat_i[BIT_IE];
               if (wb.dat_i[BIT_START] && busy) begin
                  ovr_d = 1'b1;
               end
            end
            ADDR_BAUD:   baud_d = wb.dat_i;
            ADDR_STATUS: begin
               done_d = 1'b0;
               ovr_d  = 1'b0;
            end
            ADDR_TXBUF:  txbuf_d = wb.dat_i[7:0];
            default: ;
         endcase
      end
      if (frame_end) begin
         done_d = 1'b1;
      end
   end

   always_comb begin
      rdata = '0;
      case (a)
         ADDR_CTRL: begin
            rdata[BIT_BUSY] = busy;
            rdata[BIT_IE]   = ie_q;
         end
         ADDR_BAUD: rdata = baud_q;
         ADDR_STATUS: begin
            rdata[BIT_TX_DONE]   = done_q;
            rdata[BIT_OVR]       = ovr_q;
            rdata[BIT_STAT_BUSY] = busy;
         end
         ADDR_TXBUF: rdata[7:0] = txbuf_q;
         default: ;
      endcase
      dat_o_d = rd ? rdata : dat_o_q;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         baud_q  <= '0;
         txbuf_q <= '0;
         shift_q <= '0;
         idx_q   <= '0;
         ie_q    <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         tx_q    <= 1'b1;
         ack_q   <= 1'b0;
         dat_o_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         txbuf_q <= txbuf_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         ie_q    <= ie_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         tx_q    <= tx_d;
         ack_q   <= wb.stb_i;
         dat_o_q <= dat_o_d;
      end
   end

   assign wb.dat_o = dat_o_q;
   assign wb.ack_o = ack_q;
   assign wb.err_o = 1'b0;
   assign wb.rty_o = 1'b0;
   assign tx_o     = tx_q;
   assign irq_o    = done_q & ie_q;
endmodule

// File: tb/tb_uart_tx_wb.sv
// Self-checking bench for uart_tx_wb: register vectors, randomized traffic
// and frames compared against an arithmetic tick-time model of the serial line.
module tb_uart_tx_wb;
   localparam int unsigned CLK_HZ   = 50_000_000;
   localparam logic [31:0] BAUD_115 = 32'h0096_FEB5;
   localparam logic [31:0] A_CTRL   = 32'd3;
   localparam logic [31:0] A_BAUD   = 32'd4;
   localparam logic [31:0] A_STAT   = 32'd5;
   localparam logic [31:0] A_TXBUF  = 32'd7;

   logic clk = 1'b0;
   logic rst_n;
   logic tx, irq;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] rdv;

   uart_tx_wb_if #(.ADDR_W(32)) bus ();

   uart_tx_wb #(.ADDR_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .wb    (bus.slave),
      .tx_o  (tx),
      .irq_o (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc1();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
      bus.addr_i = a;
      bus.dat_i  = d;
      bus.we_i   = 1'b1;
      bus.stb_i  = 1'b1;
      cyc1();
      bus.stb_i  = 1'b0;
      bus.we_i   = 1'b0;
      chk("write_ack", {31'b0, bus.ack_o}, 32'd1);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      bus.addr_i = a;
      bus.we_i   = 1'b0;
      bus.stb_i  = 1'b1;
      cyc1();
      bus.stb_i  = 1'b0;
      chk("read_ack", {31'b0, bus.ack_o}, 32'd1);
      d = bus.dat_o;
   endtask

   task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      wb_read(a, v);
      chk(name, v, exp);
   endtask

   // Edge index (counted from the start-write edge) of the k-th carry-out.
   function automatic longint unsigned tick_edge(input int k, input logic [31:0] inc);
      longint unsigned num;
      num = (64'(k) << 32) + 64'(inc) - 64'd1;
      return num / 64'(inc);
   endfunction

   task automatic run_frame(input logic [7:0] data, input logic [31:0] inc, input logic ie,
                            input int ovr_at, input int rd_at, input logic [31:0] rd_exp,
                            input int clr_at);
      longint unsigned t[11];
      logic [9:0] bits;
      int bad[10];
      int last;
      wb_write(A_BAUD, inc);
      wb_write(A_TXBUF, {$urandom_range(0, 255), 16'h0, data});
      bits = {1'b1, data, 1'b0};
      for (int k = 0; k <= 10; k++) t[k] = (k == 0) ? 64'd0 : tick_edge(k, inc);
      for (int j = 0; j < 10; j++) bad[j] = 0;
      last = int'(t[10]) + 1;
      wb_write(A_CTRL, {24'h0, 1'b1, 6'h0, ie});
      for (int m = 1; m <= last; m++) begin
         if (m == ovr_at) begin
            bus.addr_i = A_CTRL; bus.dat_i = {24'h0, 1'b1, 6'h0, ie};
            bus.we_i = 1'b1; bus.stb_i = 1'b1;
         end else if (m == clr_at) begin
            bus.addr_i = A_STAT; bus.dat_i = 32'h0;
            bus.we_i = 1'b1; bus.stb_i = 1'b1;
         end else if (m == rd_at) begin
            bus.addr_i = A_STAT; bus.we_i = 1'b0; bus.stb_i = 1'b1;
         end else begin
            bus.stb_i = 1'b0; bus.we_i = 1'b0;
         end
         cyc1();
         bus.stb_i = 1'b0;
         bus.we_i  = 1'b0;
         if (m == rd_at) chk("mid_frame_status", bus.dat_o, rd_exp);
         if (m == int'(t[10]) - 1) chk("irq_before_end", {31'b0, irq}, 32'd0);
         if (m == int'(t[10])) chk("irq_at_end", {31'b0, irq}, {31'b0, ie});
         for (int j = 0; j < 10; j++)
            if (64'(m) > t[j] && 64'(m) <= t[j+1] && tx !== bits[j]) bad[j]++;
         if (m == last) chk("tx_idle_after_stop", {31'b0, tx}, 32'd1);
      end
      for (int j = 0; j < 10; j++)
         chk($sformatf("tx_bit%0d_wrong_cycles", j), bad[j], 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] m_baud, m_txbuf, exp, a, d;
      logic        m_ie, is_wr;
      logic [7:0]  rb;
      logic [31:0] rinc;

      rst_n = 1'b0;
      bus.addr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0;
      bus.sel_i = 4'hF; bus.cyc_i = 1'b1; bus.stb_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_tx", {31'b0, tx}, 32'd1);
      chk("reset_ack", {31'b0, bus.ack_o}, 32'd0);
      chk("reset_dat_o", bus.dat_o, 32'd0);
      chk("reset_irq", {31'b0, irq}, 32'd0);
      rst_n = 1'b1;
      cyc1();
      chk("idle_tx", {31'b0, tx}, 32'd1);
      check_read("reset_status", A_STAT, 32'h0);
      check_read("reset_baud", A_BAUD, 32'h0);

      vecs[0]  = '{1'b1, 32'd4,         32'hDEAD_BEEF, 32'h0};
      vecs[1]  = '{1'b0, 32'd4,         32'h0,         32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 32'd7,         32'hFFFF_FFA5, 32'h0};
      vecs[3]  = '{1'b0, 32'd7,         32'h0,         32'h0000_00A5};
      vecs[4]  = '{1'b1, 32'd3,         32'h0000_0001, 32'h0};
      vecs[5]  = '{1'b0, 32'd3,         32'h0,         32'h0000_0001};
      vecs[6]  = '{1'b0, 32'd5,         32'h0,         32'h0};
      vecs[7]  = '{1'b1, 32'd6,         32'h1234,      32'h0};
      vecs[8]  = '{1'b0, 32'd6,         32'h0,         32'h0};
      vecs[9]  = '{1'b0, 32'd0,         32'h0,         32'h0};
      vecs[10] = '{1'b0, 32'hFFFF_FFFB, 32'h0,         32'h0000_0001};
      vecs[11] = '{1'b1, 32'd5,         32'hFF,        32'h0};
      vecs[12] = '{1'b0, 32'd5,         32'h0,         32'h0};
      vecs[13] = '{1'b1, 32'd3,         32'h0,         32'h0};
      vecs[14] = '{1'b0, 32'd3,         32'h0,         32'h0};
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].we) wb_write(vecs[i].addr, vecs[i].data);
         else check_read($sformatf("vec%0d_read", i), vecs[i].addr, vecs[i].exp);
      end
      chk("vec_irq_low", {31'b0, irq}, 32'd0);
      chk("vec_tx_idle", {31'b0, tx}, 32'd1);

      // Random idle register traffic against a register-array model.
      m_baud = 32'hDEAD_BEEF; m_txbuf = 32'hA5; m_ie = 1'b0;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         d = $urandom;
         is_wr = 1'($urandom_range(0, 1));
         if (a[2:0] == 3'd3) d[7] = 1'b0;
         if (is_wr) begin
            wb_write(a, d);
            case (a[2:0])
               3'd3: m_ie = d[0];
               3'd4: m_baud = d;
               3'd7: m_txbuf = {24'h0, d[7:0]};
               default: ;
            endcase
         end else begin
            case (a[2:0])
               3'd3: exp = {31'h0, m_ie};
               3'd4: exp = m_baud;
               3'd7: exp = m_txbuf;
               default: exp = 32'h0;
            endcase
            check_read($sformatf("rand_read_a%0d", a[2:0]), a, exp);
         end
      end

      // Back-to-back strobes, one result per cycle.
      wb_write(A_BAUD, 32'h1234_5678);
      wb_write(A_TXBUF, 32'h9A);
      wb_write(A_CTRL, 32'h01);
      bus.we_i = 1'b0; bus.stb_i = 1'b1;
      bus.addr_i = A_BAUD;  cyc1(); chk("b2b_baud", bus.dat_o, 32'h1234_5678);
      bus.addr_i = A_TXBUF; cyc1(); chk("b2b_txbuf", bus.dat_o, 32'h9A);
      bus.addr_i = A_CTRL;  cyc1(); chk("b2b_ctrl", bus.dat_o, 32'h01);
      chk("b2b_ack", {31'b0, bus.ack_o}, 32'd1);
      bus.stb_i = 1'b0;
      cyc1();
      chk("ack_drops", {31'b0, bus.ack_o}, 32'd0);

      // 115200 Bd frame of 0x52.
      run_frame(8'h52, BAUD_115, 1'b0, -1, -1, 32'h0, -1);
      check_read("status_after_frame", A_STAT, 32'h20);
      wb_write(A_STAT, 32'h0);

      // Start while busy: OVR set, frame untouched.
      run_frame(8'h52, BAUD_115, 1'b0, 1000, 1500, 32'h41, -1);
      check_read("status_after_ovr", A_STAT, 32'h60);
      wb_write(A_STAT, 32'h0);
      check_read("status_cleared", A_STAT, 32'h0);

      // Status clear on the edge that ends STOP.
      run_frame(8'hA5, 32'h1000_0000, 1'b0, -1, -1, 32'h0,
                int'(tick_edge(10, 32'h1000_0000)));
      check_read("status_conflict", A_STAT, 32'h20);
      wb_write(A_STAT, 32'h0);

      // Interrupt enable.
      run_frame(8'h41, 32'h1000_0000, 1'b1, -1, -1, 32'h0, -1);
      chk("irq_held", {31'b0, irq}, 32'd1);
      wb_write(A_STAT, 32'h0);
      chk("irq_cleared", {31'b0, irq}, 32'd0);

      for (int i = 0; i < 6; i++) begin
         rb   = 8'($urandom);
         rinc = $urandom_range(32'h1000_0000, 32'h4000_0000);
         run_frame(rb, rinc, 1'($urandom_range(0, 1)), -1, -1, 32'h0, -1);
         check_read("rand_frame_status", A_STAT, 32'h20);
         wb_write(A_STAT, 32'h0);
      end
      wb_write(A_CTRL, 32'h0);

      // BAUD=0 stalls in START until a nonzero increment arrives.
      wb_write(A_BAUD, 32'h0);
      wb_write(A_TXBUF, 32'h33);
      wb_write(A_CTRL, 32'h80);
      repeat (50) cyc1();
      chk("baud0_tx_low", {31'b0, tx}, 32'd0);
      check_read("baud0_status", A_STAT, 32'h01);
      wb_write(A_BAUD, 32'h4000_0000);
      repeat (60) cyc1();
      check_read("baud0_recovered", A_STAT, 32'h20);
      chk("baud0_tx_idle", {31'b0, tx}, 32'd1);
      wb_write(A_STAT, 32'h0);

      // Reset during DATA bit 3 (16 cycles per bit, bit 3 occupies edges 65..80).
      wb_write(A_BAUD, 32'h1000_0000);
      wb_write(A_TXBUF, 32'h52);
      wb_write(A_CTRL, 32'h80);
      repeat (70) cyc1();
      chk("pre_reset_tx_bit3", {31'b0, tx}, 32'd0);
      #1 rst_n = 1'b0;
      #1 chk("reset_async_tx", {31'b0, tx}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc1();
      chk("post_reset_tx", {31'b0, tx}, 32'd1);
      check_read("post_reset_status", A_STAT, 32'h0);
      check_read("post_reset_baud", A_BAUD, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
